// File: rtl/nibble_packer.sv
// nibble_packer: packs N serial W-bit elements into one N*W-bit word behind a valid/ready output register (optional word_cnt via NIBBLE_PACKER_WORDCNT_EN)
module nibble_packer #(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [N*W-1:0] out_word,
   output logic           out_valid,
   input  logic           out_ready
`ifdef NIBBLE_PACKER_WORDCNT_EN
   ,output logic [7:0]    word_cnt
`endif
);
   localparam int CW = $clog2(N);
   logic [N*W-1:0] asm;
   logic [CW-1:0]  cnt;
   logic           asm_full;
   logic           in_fire, out_fire, out_free, last, load_asm, load_direct;
   assign in_ready    = !asm_full;
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;
   assign out_free    = !out_valid | out_ready;
   assign last        = cnt == CW'(N - 1);
   assign load_asm    = asm_full & out_free;
   assign load_direct = in_fire & last & out_free;
   // elements shift in from the LSB end, so after N beats the first one sits in the MS slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm       <= '0;
         cnt       <= '0;
         asm_full  <= 1'b0;
         out_word  <= '0;
         out_valid <= 1'b0;
      end else if (clr) begin
         cnt       <= '0;
         asm_full  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (in_fire) asm <= {asm[N*W-W-1:0], in_data};
         if (load_asm) out_word <= asm;
         else if (load_direct) out_word <= {asm[N*W-W-1:0], in_data};
         out_valid <= (load_asm | load_direct) ? 1'b1 : out_fire ? 1'b0 : out_valid;
         asm_full  <= load_asm ? 1'b0 : (in_fire & last & !out_free) ? 1'b1 : asm_full;
         cnt       <= (load_asm | load_direct) ? '0 : (in_fire & !last) ? cnt + 1'b1 : cnt;
      end
   end
`ifdef NIBBLE_PACKER_WORDCNT_EN
   // counts words taken by the consumer, wrapping at 8 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) word_cnt <= '0;
      else if (clr) word_cnt <= '0;
      else if (out_fire) word_cnt <= word_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed and random checks of nibble_packer against a queue-based reference model
module tb_nibble_packer;
   localparam int W = 4;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           rst, clr, in_valid, out_ready;
   logic [W-1:0]   in_data;
   logic           in_ready, out_valid;
   logic [N*W-1:0] out_word;
`ifdef NIBBLE_PACKER_WORDCNT_EN
   logic [7:0]     word_cnt;
`endif
   logic [7:0]     m_wc;
   logic [W-1:0]   m_asm[$];
   logic           m_has;
   logic [N*W-1:0] m_word;
   int             compared = 0;
   int             mismatched = 0;

   always #5 clk = ~clk;

   nibble_packer #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready)
`ifdef NIBBLE_PACKER_WORDCNT_EN
      , .word_cnt(word_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pack();
      logic [N*W-1:0] w = '0;
      for (int i = 0; i < N; i++) w = w | ((N*W)'(m_asm[i]) << ((N - 1 - i) * W));
      return w;
   endfunction

   task automatic model_reset();
      m_asm.delete();
      m_has = 1'b0;
      m_word = '0;
      m_wc = '0;
   endtask

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic c);
      logic fire, ofire, free;
      in_valid = v;
      in_data = d;
      out_ready = ordy;
      clr = c;
      chk("in_ready", in_ready, m_asm.size() < N);
      chk("out_valid", out_valid, m_has);
      if (m_has) chk("out_word", out_word, m_word);
`ifdef NIBBLE_PACKER_WORDCNT_EN
      chk("word_cnt", word_cnt, m_wc);
`endif
      fire = v && (m_asm.size() < N);
      ofire = m_has && ordy;
      free = !m_has || ordy;
      if (c) begin
         m_asm.delete();
         m_has = 1'b0;
         m_wc = '0;
      end else begin
         if (ofire) begin
            m_has = 1'b0;
            m_wc = m_wc + 8'd1;
         end
         if (m_asm.size() == N) begin
            if (free) begin
               m_word = pack();
               m_has = 1'b1;
               m_asm.delete();
            end
         end else if (fire) begin
            m_asm.push_back(d);
            if (m_asm.size() == N && free) begin
               m_word = pack();
               m_has = 1'b1;
               m_asm.delete();
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_word", out_word, 16'h0);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      // basic pack
      cyc(1, 4'h4, 1, 0); cyc(1, 4'h3, 1, 0); cyc(1, 4'h2, 1, 0); cyc(1, 4'h1, 1, 0);
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_word", out_word, 16'h4321);
      cyc(0, 0, 1, 0);
      chk("basic_drop", out_valid, 1'b0);
      // back-to-back
      for (int i = 1; i <= 8; i++) begin
         cyc(1, W'(i), 1, 0);
         if (i == 4) chk("b2b_w0", out_word, 16'h1234);
         if (i == 8) chk("b2b_w1", out_word, 16'h5678);
      end
      cyc(0, 0, 1, 0);
      // output stall
      cyc(1, 4'hA, 0, 0); cyc(1, 4'hB, 0, 0); cyc(1, 4'hC, 0, 0); cyc(1, 4'hD, 0, 0);
      cyc(1, 4'hE, 0, 0); cyc(1, 4'hF, 0, 0); cyc(1, 4'h7, 0, 0); cyc(1, 4'h0, 0, 0);
      cyc(1, 4'h5, 0, 0);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_word", out_word, 16'hABCD);
      cyc(0, 0, 1, 0);
      chk("stall_next", out_word, 16'hEF70);
      chk("stall_next_valid", out_valid, 1'b1);
      chk("stall_ready_back", in_ready, 1'b1);
      cyc(0, 0, 1, 0);
      // input gaps
      cyc(1, 4'h9, 1, 0); cyc(0, 4'h1, 1, 0); cyc(1, 4'h0, 1, 0); cyc(0, 4'h2, 1, 0);
      cyc(1, 4'hF, 1, 0); cyc(0, 4'h3, 1, 0); cyc(1, 4'h5, 1, 0);
      chk("gap_word", out_word, 16'h90F5);
      cyc(0, 0, 1, 0);
      // clr mid-word
      cyc(1, 4'h1, 1, 0); cyc(1, 4'h2, 1, 0); cyc(1, 4'h3, 1, 1);
      cyc(1, 4'h6, 1, 0); cyc(1, 4'h7, 1, 0); cyc(1, 4'h8, 1, 0); cyc(1, 4'h9, 1, 0);
      chk("clr_word", out_word, 16'h6789);
      cyc(0, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      // async reset while a word is held
      cyc(1, 4'h1, 0, 0); cyc(1, 4'h2, 0, 0); cyc(1, 4'h3, 0, 0); cyc(1, 4'h4, 0, 0);
      cyc(1, 4'h5, 0, 0);
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_out_valid", out_valid, 1'b0);
      chk("async_out_word", out_word, 16'h0);
      chk("async_in_ready", in_ready, 1'b1);
`ifdef NIBBLE_PACKER_WORDCNT_EN
      chk("async_word_cnt", word_cnt, 8'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cyc(0, 0, 1, 0);
      // 256 words wrap the word counter back to zero
      for (int i = 0; i < 256 * N; i++) cyc(1, W'($urandom), 1, 0);
      cyc(0, 0, 1, 0);
`ifdef NIBBLE_PACKER_WORDCNT_EN
      chk("wc_wrap", word_cnt, 8'd0);
`endif
      cyc(0, 0, 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Upstream feeder for the 4-nibble sorting network.
- Accepts a serial stream of W-bit values over a valid/ready handshake and packs N consecutive values into one N*W-bit word.
- Presents the packed word on a registered valid/ready output that drives the sorter input.
- Has one assembly buffer and one output buffer, so input streaming continues while a finished word waits for the consumer.

Parameters:
W, 4, width of one input element (nibble)
N, 4, elements per packed word; N >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear: discards partial assembly and output word
in_data  input  W  element value
in_valid  input  1  in_data valid this cycle
in_ready  output  1  packer can accept an element this cycle
out_word  output  N*W  packed word; first-received element in bits [N*W-1 -: W], last in [W-1:0]
out_valid  output  1  out_word holds a complete word
out_ready  input  1  consumer takes out_word this cycle

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_free = !out_valid | out_ready.
- State:
  - asm[N*W-1:0]: assembly buffer.
  - cnt in 0..N-1: next slot to fill.
  - asm_full: 1 bit.
  - out register plus out_valid.
- Reset (rst high, asynchronous): asm=0, cnt=0, asm_full=0, out_word=0, out_valid=0. in_ready is 1 one cycle after rst deasserts.
- in_ready = !asm_full (combinational from state only, never from in_valid or out_ready).
- on in_fire with cnt < N-1: write in_data into slot cnt (slot 0 = MS element); cnt <= cnt+1.
- on in_fire with cnt == N-1 (word completes):
  - if out_free: out_word <= {asm upper slots, in_data}; out_valid <= 1; cnt <= 0; asm_full stays 0.
  - else: write the last slot, asm_full <= 1; cnt holds N-1.
- asm_full & out_free: out_word <= asm; out_valid <= 1; asm_full <= 0; cnt <= 0. in_ready returns to 1 the next cycle.
- out_fire with no new word loaded that cycle: out_valid <= 0. out_word keeps its last value (don't-care while out_valid=0).
- Latency: word is valid on the cycle after its last element is accepted.
- Throughput: with out_ready held 1, one element per cycle sustained, one word every N cycles, no bubbles.
- Stall: out_ready=0 with out_valid=1 → assembly of the next word proceeds. When it completes, asm_full=1 and in_ready=0 until the output drains.
- out_word/out_valid are stable while out_valid=1 and out_ready=0 (no change until out_fire or clr).
- clr (synchronous, priority over all handshakes that cycle): cnt=0, asm_full=0, out_valid=0. An element presented that cycle is dropped. in_ready is 1 the next cycle.
- rst asserted mid-word or mid-stall: immediate return to reset state; partial data lost.
- Element values are passed bit-exact; no arithmetic or reordering (sorting is the downstream stage's job).

Optional Feature:
- Macro NIBBLE_PACKER_WORDCNT_EN.
- Defined:
  - adds output port word_cnt (8 bits), counting out_fire events.
  - reset to 0 by rst or clr.
  - wraps 255 → 0.
  - updates the cycle after the fire.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic pack: out_ready=1; send 4,3,2,1 on consecutive cycles → out_valid=1 one cycle after the 4th beat, out_word=16'h4321, then out_valid=0.
- Back-to-back: out_ready=1; stream 8 elements 1..8 continuously → in_ready stays 1; words 16'h1234 and 16'h5678 each valid exactly one cycle, 4 cycles apart.
- Output stall: out_ready=0; send A,B,C,D then E,F,7,0 → out_word=16'hABCD held stable; after the 8th beat in_ready=0. Raise out_ready:
  - 16'hABCD fires;
  - next cycle out_word=16'hEF70 valid;
  - in_ready=1 again.
- Input gaps: in_valid toggles 1/0 while sending 9,0,F,5 → single word 16'h90F5; no element lost or duplicated.
- clr mid-word: send 1,2 then assert clr with in_valid=1 (data 3); then send 6,7,8,9 → only 16'h6789 emitted; out_valid never shows a word containing 1 or 2.
- Async reset: assert rst between clock edges while out_valid=1 → out_valid=0 and out_word=0 immediately. With NIBBLE_PACKER_WORDCNT_EN, word_cnt=0, and after 256 words word_cnt=0.
